resp_frame_builder: RTL and testbench

Parametrised response-frame builder for the UART-AXI4 bridge. It takes a response request (status, echoed command, echoed address, payload length) over a valid/ready handshake and streams the payload bytes in from the read-data path rather than from a copied array. It emits a device-to-host frame (SOF, STATUS, CMD, [ADDR, DATA], CRC8) byte-by-byte into the UART TX FIFO, with back-pressure on every byte and a configurable inter-frame gap.

---
 rtl/resp_frame_builder.sv | 163 ++++++++++++++++
 tb/tb_resp_frame_builder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_frame_builder.sv
// Builds a device-to-host response frame (SOF, STATUS, CMD, [ADDR, DATA], CRC8) byte by byte.
// Latency: SOF presented the cycle after request acceptance, then one byte per cycle unstalled.
// Backpressure: every byte waits on tx_ready; payload passes through from data_* with zero latency.
module resp_frame_builder #(
  parameter int         MAX_DATA_BYTES = 64,
  parameter int         ADDR_BYTES     = 4,
  parameter logic [7:0] SOF_BYTE       = 8'h5A,
  parameter int         GAP_CYCLES     = 1,
  localparam int        LW             = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_status,
  input  logic [7:0]              req_cmd,
  input  logic [ADDR_BYTES*8-1:0] req_addr,
  input  logic [LW-1:0]           req_len,
  input  logic                    data_valid,
  input  logic [7:0]              data_byte,
  output logic                    data_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int AW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(ADDR_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_STATUS, S_CMD, S_ADDR, S_DATA, S_CRC, S_GAP
  } state_t;

  state_t                  state, state_nxt;
  logic [7:0]              status_q, cmd_q, crc_q;
  logic [ADDR_BYTES*8-1:0] addr_q;
  logic [LW-1:0]           len_q, dcnt;
  logic [AW-1:0]           aidx;
  logic [GW-1:0]           gcnt;
  logic                    rd_q;
  logic                    accept, xfer;

  // CRC-8 poly 0x07, MSB first, one byte per call
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] r;
    r = crc ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // req_ready is gated by reset so nothing can be accepted while rst_n is low
  assign req_ready = rst_n && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign xfer      = tx_valid && tx_ready;
  assign busy      = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and byte mux; tx_valid never looks at tx_ready
  always_comb begin
    state_nxt  = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    data_ready = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_SOF;
      S_SOF: begin
        tx_valid = 1'b1;
        tx_data  = SOF_BYTE;
        if (tx_ready) state_nxt = S_STATUS;
      end
      S_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = status_q;
        if (tx_ready) state_nxt = S_CMD;
      end
      S_CMD: begin
        tx_valid = 1'b1;
        tx_data  = cmd_q;
        if (tx_ready) state_nxt = rd_q ? S_ADDR : S_CRC;
      end
      S_ADDR: begin
        tx_valid = 1'b1;
        tx_data  = addr_q[aidx*8 +: 8];
        if (tx_ready && aidx == ADDR_LAST) state_nxt = (len_q == '0) ? S_CRC : S_DATA;
      end
      S_DATA: begin
        tx_valid   = data_valid;
        tx_data    = data_byte;
        data_ready = tx_ready;
        if (data_valid && tx_ready && dcnt == len_q - LW'(1)) state_nxt = S_CRC;
      end
      S_CRC: begin
        tx_valid = 1'b1;
        tx_data  = crc_q;
        if (tx_ready) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: if (gcnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, byte counters and running CRC; all advance only on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 8'h00;
      cmd_q    <= 8'h00;
      addr_q   <= '0;
      len_q    <= '0;
      rd_q     <= 1'b0;
      crc_q    <= 8'h00;
      aidx     <= '0;
      dcnt     <= '0;
    end else begin
      if (accept) begin
        status_q <= req_status;
        cmd_q    <= req_cmd;
        addr_q   <= req_addr;
        len_q    <= (req_len > LEN_MAX) ? LEN_MAX : req_len;
        rd_q     <= (req_status == 8'h00) && req_cmd[7];
        crc_q    <= 8'h00;
        aidx     <= '0;
        dcnt     <= '0;
      end
      if (xfer) begin
        case (state)
          S_STATUS, S_CMD: crc_q <= crc8_step(crc_q, tx_data);
          S_ADDR: begin
            crc_q <= crc8_step(crc_q, tx_data);
            aidx  <= aidx + AW'(1);
          end
          S_DATA: begin
            crc_q <= crc8_step(crc_q, tx_data);
            dcnt  <= dcnt + LW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Gap counter restarts every time GAP is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gcnt <= '0;
    else        gcnt <= (state == S_GAP) ? gcnt + GW'(1) : '0;
  end

  // frame_done pulses for the cycle following the CRC byte transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= xfer && (state == S_CRC);
  end

endmodule

// File: tb/tb_resp_frame_builder.sv
// Directed frame vectors applied through a table loop, plus a mid-frame reset sequence.
// Latency: checks SOF one cycle after acceptance, frame_done and req_ready spacing after CRC.
// Backpressure: optional random tx_ready / data_valid stalls per vector.
`timescale 1ns/1ps
module tb_resp_frame_builder;
  localparam int MAXB = 64;
  localparam int AB   = 4;
  localparam int GAP  = 2;
  localparam int LW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_status = 8'h00;
  logic [7:0]    req_cmd = 8'h00;
  logic [AB*8-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          data_valid = 1'b0;
  logic [7:0]    data_byte = 8'h00;
  logic          data_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          frame_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  resp_frame_builder #(
    .MAX_DATA_BYTES(MAXB), .ADDR_BYTES(AB), .SOF_BYTE(8'h5A), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_status(req_status), .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len),
    .data_valid(data_valid), .data_byte(data_byte), .data_ready(data_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0]  status;
    logic [7:0]  cmd;
    logic [31:0] addr;
    int          len;
    int          supply;     // payload bytes offered by the source
    int          pat;        // 0: bytes of word MSB first, 1: i*7+3
    logic [31:0] word;
    bit          stall;
    int          abort_at;   // >0: reset when this many bytes have gone out
    int          exp_bytes;
    int          exp_cons;
    bit          chk_crc;
    logic [7:0]  exp_crc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input int id, input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL v%0d %s actual=0x%0h required=0x%0h", id, nm, act, req);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] st, input logic [7:0] cmd, input logic [31:0] addr,
                              input int len, input int supply, input int pat, input logic [31:0] word,
                              input bit stall, input int abort_at, input int exp_bytes,
                              input int exp_cons, input bit chk_crc, input logic [7:0] exp_crc);
    vec_t v;
    v.status = st; v.cmd = cmd; v.addr = addr; v.len = len; v.supply = supply; v.pat = pat;
    v.word = word; v.stall = stall; v.abort_at = abort_at; v.exp_bytes = exp_bytes;
    v.exp_cons = exp_cons; v.chk_crc = chk_crc; v.exp_crc = exp_crc;
    return v;
  endfunction

  task automatic run_frame(input int id, input vec_t v);
    logic [7:0] src[$];
    logic [7:0] pay[$];
    logic [7:0] exp[$];
    logic [7:0] got[$];
    logic [7:0] c, b;
    int n, cyc, acc_cyc, first_cyc, crc_cyc, fd_cyc, fd_cnt, rr_cyc, cons, bad_idx;
    bit rd, accepted, indep_bad, dr_bad, v0, v1, want, dve;

    for (int i = 0; i < v.supply; i++)
      src.push_back((v.pat == 0) ? v.word[31-8*i -: 8] : 8'(i * 7 + 3));
    pay = src;
    rd  = (v.status == 8'h00) && v.cmd[7];
    n   = (v.len > MAXB) ? MAXB : v.len;
    exp.push_back(8'h5A); exp.push_back(v.status); exp.push_back(v.cmd);
    c = crc8(8'h00, v.status);
    c = crc8(c, v.cmd);
    if (rd) begin
      for (int i = 0; i < AB; i++) begin
        b = v.addr[8*i +: 8];
        exp.push_back(b);
        c = crc8(c, b);
      end
      for (int i = 0; i < n; i++) begin
        exp.push_back(src[i]);
        c = crc8(c, src[i]);
      end
    end
    exp.push_back(c);

    accepted = 0; acc_cyc = -1; first_cyc = -1; crc_cyc = -1; fd_cyc = -1; fd_cnt = 0;
    rr_cyc = -1; cons = 0; indep_bad = 0; dr_bad = 0; cyc = 0;
    req_status = v.status; req_cmd = v.cmd; req_addr = v.addr; req_len = LW'(v.len);

    while (rr_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      req_valid  = !accepted;
      want       = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      dve        = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_valid = dve && (pay.size() > 0);
      data_byte  = (pay.size() > 0) ? pay[0] : 8'h00;
      tx_ready = 1'b0; #1 v0 = tx_valid;
      tx_ready = 1'b1; #1 v1 = tx_valid;
      tx_ready = want; #1;
      if (v0 != v1) indep_bad = 1;
      if (!accepted) begin
        if (req_ready) begin
          accepted = 1;
          acc_cyc  = cyc;
        end
      end else begin
        if (!rd && data_ready) dr_bad = 1;
        if (frame_done) begin
          fd_cnt++;
          if (fd_cyc < 0) fd_cyc = cyc;
        end
        if (crc_cyc >= 0 && req_ready) rr_cyc = cyc;
        if (tx_valid && tx_ready) begin
          if (v.abort_at > 0 && got.size() == v.abort_at) begin
            rst_n = 1'b0;
            #1;
            chk(id, "rst_tx_valid", tx_valid, 0);
            chk(id, "rst_busy", busy, 0);
            chk(id, "rst_data_ready", data_ready, 0);
            chk(id, "rst_req_ready", req_ready, 0);
            chk(id, "rst_tx_data", tx_data, 0);
            chk(id, "rst_frame_done", frame_done, 0);
            bad_idx = -1;
            for (int i = 0; i < got.size(); i++)
              if (bad_idx < 0 && got[i] !== exp[i]) bad_idx = i;
            chk(id, "abort_prefix_bad_idx", bad_idx, -1);
            data_valid = 1'b0;
            req_valid  = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
          end
          if (first_cyc < 0) first_cyc = cyc;
          got.push_back(tx_data);
          if (got.size() == exp.size()) crc_cyc = cyc;
        end
        if (data_valid && data_ready) begin
          void'(pay.pop_front());
          cons++;
        end
      end
      cyc++;
    end
    req_valid  = 1'b0;
    data_valid = 1'b0;

    chk(id, "timeout", (rr_cyc >= 0) ? 1 : 0, 1);
    chk(id, "nbytes", got.size(), v.exp_bytes);
    bad_idx = -1;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (bad_idx < 0 && got[i] !== exp[i]) bad_idx = i;
    chk(id, "seq_bad_idx", bad_idx, -1);
    if (v.chk_crc && got.size() > 0) chk(id, "crc", got[got.size()-1], v.exp_crc);
    chk(id, "consumed", cons, v.exp_cons);
    chk(id, "frame_done_pos", fd_cyc - crc_cyc, 1);
    chk(id, "frame_done_cnt", fd_cnt, 1);
    chk(id, "req_ready_after_crc", rr_cyc - crc_cyc, GAP + 1);
    chk(id, "tx_valid_indep", indep_bad, 0);
    if (!rd) chk(id, "data_ready_nonread", dr_bad, 0);
    if (!v.stall) begin
      chk(id, "accept_cycle", acc_cyc, 0);
      chk(id, "sof_latency", first_cyc - acc_cyc, 1);
      chk(id, "contiguous", crc_cyc - first_cyc, v.exp_bytes - 1);
    end
  endtask

  initial begin
    //            st     cmd    addr          len sup pat word          stl abort nb  cons crc? crc
    tbl[0] = mk(8'h00, 8'h20, 32'h0,          0,  0,  0, 32'h0,         0, 0,    4,  0,  1, 8'hE0);
    tbl[1] = mk(8'h00, 8'hA0, 32'h12345678,   4,  4,  0, 32'hDEADBEEF,  0, 0,   12,  4,  0, 8'h00);
    tbl[2] = mk(8'h03, 8'hA0, 32'h12345678,   4,  4,  0, 32'hDEADBEEF,  0, 0,    4,  0,  1, 8'h56);
    tbl[3] = mk(8'h00, 8'hA0, 32'h12345678,   4,  4,  0, 32'hDEADBEEF,  1, 0,   12,  4,  0, 8'h00);
    tbl[4] = mk(8'h00, 8'h81, 32'hAABBCCDD,   0,  2,  1, 32'h0,         0, 0,    8,  0,  0, 8'h00);
    tbl[5] = mk(8'h00, 8'hC0, 32'h00000001,  70, 70,  1, 32'h0,         0, 0,   72, 64,  0, 8'h00);
    tbl[6] = mk(8'h00, 8'hA0, 32'h12345678,   4,  4,  0, 32'hDEADBEEF,  0, 9,    0,  0,  0, 8'h00);
    tbl[7] = mk(8'h00, 8'h20, 32'h0,          0,  0,  0, 32'h0,         0, 0,    4,  0,  1, 8'hE0);
    tbl[8] = mk(8'h00, 8'h20, 32'h0,          0,  0,  0, 32'h0,         1, 0,    4,  0,  1, 8'hE0);
    tbl[9] = mk(8'h00, 8'hC0, 32'h00000005,  70, 70,  1, 32'h0,         1, 0,   72, 64,  0, 8'h00);

    // reset values, with a request already pending to show req_ready is gated
    rst_n     = 1'b0;
    req_valid = 1'b1;
    tx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk(-1, "reset_tx_valid", tx_valid, 0);
    chk(-1, "reset_req_ready", req_ready, 0);
    chk(-1, "reset_busy", busy, 0);
    chk(-1, "reset_tx_data", tx_data, 0);
    chk(-1, "reset_frame_done", frame_done, 0);
    chk(-1, "reset_data_ready", data_ready, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_frame(i, tbl[i]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=expired required=finished");
    $fatal(1, "timeout");
  end

endmodule
